acc_shift_seq: RTL and testbench
================================

// Module: acc_shift_seq
// PURPOSE
//  Parametrised double-width accumulator {AH,AL}, each half WIDTH bits, for the datapath
//  next to the ALU. Keeps per-cycle manual modes per half (load/shl/shr/hold).
//  Adds a multi-cycle shift sequencer: one start shifts the 2*WIDTH pair by shamt
//  positions with a selectable fill, under a busy/done handshake.
// PARAMETERS
//  WIDTH    8  bits per half (AH, AL); >=2
//  SHAMT_W  5  shamt width; must satisfy 2**SHAMT_W > 2*WIDTH
// PORTS
//  clk        in   1        clock, rising edge
//  clr_n      in   1        async active-low reset, all state to 0
//  ah_reset   in   1        sync clear of AH
//  ah_inen    in   1        AH load source: 1=ah_in, 0=aludata
//  ah_in      in   WIDTH    external AH load data
//  aludata    in   WIDTH    ALU result, AH load data
//  carry_out  in   1        ALU carry, shift-in bit
//  hs         in   2        AH manual mode
//  ls         in   2        AL manual mode
//  start      in   1        sequencer start, sampled when !busy
//  shamt      in   SHAMT_W  shift amount
//  dir        in   1        0=left (toward AH MSB), 1=right
//  fmode      in   2        fill: 00 zero, 01 arith, 10 carry_out, 11 rotate
//  ah_out     out  WIDTH    AH register
//  al_out     out  WIDTH    AL register
//  busy       out  1        sequence running
//  done       out  1        1-cycle pulse, sequence complete
//  sh_flag    out  1        last bit shifted out of the pair
// BEHAVIOUR
//  Reset: clr_n=0 -> ah_out=al_out=0, busy=0, done=0, sh_flag=0, count=0, async.
//  Manual (busy=0, start=0), per half on each edge:
//   00 load: AH<=ah_inen?ah_in:aludata; AL<=ah_out (old AH).
//   01 shl: AH<={AH[W-2:0],AL[W-1]}; AL<={AL[W-2:0],carry_out}.
//   10 shr: AH<={carry_out,AH[W-1:1]}; AL<={AH[0],AL[W-1:1]}.
//   11 hold. hs and ls act independently and use old values (same-edge semantics).
//   Manual shifts do not change sh_flag.
//  ah_reset (busy=0): AH<=0, overrides hs; AL still follows ls with old AH.
//  Sequencer:
//   start & !busy & shamt!=0: latch dir/fmode, count<=min(shamt,2*WIDTH), busy<=1.
//    Manual modes ignored on that edge.
//   start & !busy & shamt==0: no register change; done=1 next cycle, busy stays 0.
//   busy: each edge shifts {AH,AL} by 1 in latched dir, count-=1, sh_flag<=bit out.
//   Last shift (count==1): busy<=0 and done<=1 on the same edge; done is low on the next edge.
//   Latency: busy high for exactly min(shamt,2*WIDTH) cycles.
//   Fill bit: 00 -> 0. 01 -> right: AH[W-1] (sign); left: 0.
//    10 -> carry_out sampled each shift. 11 -> bit shifted out (rotate), see CONFIGURATION.
//   start while busy: ignored. hs/ls while busy: ignored.
//   ah_reset while busy: abort. AH<=0, AL holds, busy<=0, done stays 0, count<=0.
//   shamt > 2*WIDTH saturates. Example: logical shift by 16 at W=8 gives 0.
//  Async reset mid-sequence: immediate return to reset state; no done.
// CONFIGURATION
//  ROTATE_EN defined: fmode=11 rotates the 2*WIDTH pair, the out bit re-enters at the far end.
//  ROTATE_EN undefined: fmode=11 behaves as fmode=00 (zero fill); no rotate logic built.
// TESTING (WIDTH=8)
//  reset: clr_n=0 mid-busy -> all outputs 0 at once; no done after release.
//  manual: hs=00 with ah_inen=1, ah_in=A5, ls=11 -> AH=A5.
//   Then hs=01, ls=01, carry_out=1 -> AH=4A, AL=01.
//  seq shr arith: AH=80, AL=00, shamt=4, dir=1, fmode=01 -> busy 4 cycles.
//   Result AH=F8, AL=00; done pulse 1 cycle; sh_flag=0.
//  rotate (ROTATE_EN): AH=00, AL=01, dir=1, shamt=1, fmode=11 -> AH=80, AL=00, sh_flag=1.
//   Without ROTATE_EN -> AH=00, AL=00.
//  boundaries: shamt=0 -> done only, no busy. shamt=31 logical -> busy 16 cycles, pair 0.
//   start during busy -> no effect.
//  abort: ah_reset in 2nd busy cycle -> AH=00, AL holds, busy=0, no done.

Source files
------------

// File: rtl/acc_shift_seq_if.sv
// Bus bundle for acc_shift_seq: manual-mode controls, sequencer handshake and register outputs.
interface acc_shift_seq_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 5
);
  logic               ah_reset;
  logic               ah_inen;
  logic [WIDTH-1:0]   ah_in;
  logic [WIDTH-1:0]   aludata;
  logic               carry_out;
  logic [1:0]         hs;
  logic [1:0]         ls;
  logic               start;
  logic [SHAMT_W-1:0] shamt;
  logic               dir;
  logic [1:0]         fmode;
  logic [WIDTH-1:0]   ah_out;
  logic [WIDTH-1:0]   al_out;
  logic               busy;
  logic               done;
  logic               sh_flag;

  // Driver side (datapath control)
  modport master (
    output ah_reset, ah_inen, ah_in, aludata, carry_out, hs, ls,
           start, shamt, dir, fmode,
    input  ah_out, al_out, busy, done, sh_flag
  );

  // Accumulator side
  modport slave (
    input  ah_reset, ah_inen, ah_in, aludata, carry_out, hs, ls,
           start, shamt, dir, fmode,
    output ah_out, al_out, busy, done, sh_flag
  );
endinterface

// File: rtl/acc_shift_seq.sv
// Double-width accumulator {AH,AL} with per-half manual modes and a multi-cycle
// shift sequencer (busy/done handshake). Optional macro ROTATE_EN enables
// rotate fill for fmode=11; without it fmode=11 is a zero fill.
module acc_shift_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           clr_n,
  acc_shift_seq_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   ah_q;
  logic [WIDTH-1:0]   al_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic [1:0]         fmode_q;
  logic               done_q;
  logic               sh_flag_q;

  logic [WIDTH-1:0]   ah_man_d;
  logic [WIDTH-1:0]   al_man_d;
  logic [PW-1:0]      pair_c;
  logic [PW-1:0]      pair_sh_d;
  logic               out_bit_c;
  logic               fill_bit_c;
  logic [SHAMT_W-1:0] cnt_start_d;

  // Manual per-half next values; both halves see the old register contents
  always_comb begin
    ah_man_d = ah_q;
    al_man_d = al_q;
    unique case (bus.hs)
      2'b00:   ah_man_d = bus.ah_inen ? bus.ah_in : bus.aludata;
      2'b01:   ah_man_d = {ah_q[WIDTH-2:0], al_q[WIDTH-1]};
      2'b10:   ah_man_d = {bus.carry_out, ah_q[WIDTH-1:1]};
      default: ah_man_d = ah_q;
    endcase
    if (bus.ah_reset) ah_man_d = '0;
    unique case (bus.ls)
      2'b00:   al_man_d = ah_q;
      2'b01:   al_man_d = {al_q[WIDTH-2:0], bus.carry_out};
      2'b10:   al_man_d = {ah_q[0], al_q[WIDTH-1:1]};
      default: al_man_d = al_q;
    endcase
  end

  // One-step shift of the pair in the latched direction with the latched fill
  always_comb begin
    pair_c     = {ah_q, al_q};
    out_bit_c  = dir_q ? pair_c[0] : pair_c[PW-1];
    fill_bit_c = 1'b0;
    case (fmode_q)
      2'b01:   fill_bit_c = dir_q ? pair_c[PW-1] : 1'b0;
      2'b10:   fill_bit_c = bus.carry_out;
`ifdef ROTATE_EN
      2'b11:   fill_bit_c = out_bit_c;
`endif
      default: fill_bit_c = 1'b0;
    endcase
    pair_sh_d   = dir_q ? {fill_bit_c, pair_c[PW-1:1]} : {pair_c[PW-2:0], fill_bit_c};
    cnt_start_d = (bus.shamt > SHAMT_W'(PW)) ? SHAMT_W'(PW) : bus.shamt;
  end

  // Sequencer FSM and accumulator registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      ah_q      <= '0;
      al_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      fmode_q   <= 2'b00;
      done_q    <= 1'b0;
      sh_flag_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.shamt != '0) begin
              dir_q   <= bus.dir;
              fmode_q <= bus.fmode;
              cnt_q   <= cnt_start_d;
              state_q <= S_BUSY;
            end else begin
              done_q <= 1'b1;
            end
          end else begin
            ah_q <= ah_man_d;
            al_q <= al_man_d;
          end
        end
        S_BUSY: begin
          if (bus.ah_reset) begin
            ah_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            {ah_q, al_q} <= pair_sh_d;
            sh_flag_q    <= out_bit_c;
            cnt_q        <= cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ah_out  = ah_q;
  assign bus.al_out  = al_q;
  assign bus.busy    = (state_q == S_BUSY);
  assign bus.done    = done_q;
  assign bus.sh_flag = sh_flag_q;

endmodule

// File: tb/tb_acc_shift_seq.sv
// Self-checking bench for acc_shift_seq (WIDTH=8): directed cases plus random
// stimulus against an arithmetic reference model of the accumulator pair.
module tb_acc_shift_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 5;

  logic clk;
  logic clr_n;

  acc_shift_seq_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  acc_shift_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pair held as a plain 16-bit number, remaining shift count
  int unsigned m_ah, m_al, m_rem;
  bit          m_busy, m_done, m_flag, m_dir;
  bit [1:0]    m_fm;

  always @(posedge clk or negedge clr_n) begin
    int unsigned p, nah, nal, o, f, c;
    if (!clr_n) begin
      m_ah = 0; m_al = 0; m_rem = 0;
      m_busy = 0; m_done = 0; m_flag = 0; m_dir = 0; m_fm = 0;
    end else begin
      m_done = 0;
      c = int'(bus.carry_out);
      if (!m_busy) begin
        if (bus.start) begin
          if (bus.shamt != 0) begin
            m_rem  = (int'(bus.shamt) > 16) ? 16 : int'(bus.shamt);
            m_busy = 1; m_dir = bus.dir; m_fm = bus.fmode;
          end else begin
            m_done = 1;
          end
        end else begin
          case (bus.hs)
            2'b00:   nah = bus.ah_inen ? int'(bus.ah_in) : int'(bus.aludata);
            2'b01:   nah = ((m_ah * 2) + (m_al / 128)) % 256;
            2'b10:   nah = c * 128 + m_ah / 2;
            default: nah = m_ah;
          endcase
          if (bus.ah_reset) nah = 0;
          case (bus.ls)
            2'b00:   nal = m_ah;
            2'b01:   nal = (m_al * 2 + c) % 256;
            2'b10:   nal = (m_ah % 2) * 128 + m_al / 2;
            default: nal = m_al;
          endcase
          m_ah = nah; m_al = nal;
        end
      end else if (bus.ah_reset) begin
        m_ah = 0; m_busy = 0; m_rem = 0;
      end else begin
        p = m_ah * 256 + m_al;
        o = m_dir ? p % 2 : p / 32768;
        case (m_fm)
          2'b01: f = m_dir ? p / 32768 : 0;
          2'b10: f = c;
`ifdef ROTATE_EN
          2'b11: f = o;
`endif
          default: f = 0;
        endcase
        if (m_dir) p = f * 32768 + p / 2;
        else       p = (p * 2) % 65536 + f;
        m_ah = p / 256; m_al = p % 256; m_flag = o[0];
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("ah_out",  int'(bus.ah_out),  m_ah);
    chk("al_out",  int'(bus.al_out),  m_al);
    chk("busy",    int'(bus.busy),    int'(m_busy));
    chk("done",    int'(bus.done),    int'(m_done));
    chk("sh_flag", int'(bus.sh_flag), int'(m_flag));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ah_reset = 0; bus.start = 0; bus.hs = 2'b11; bus.ls = 2'b11;
  endtask

  task automatic set_pair(input logic [7:0] ah, input logic [7:0] al);
    bus.ah_inen = 1; bus.ah_in = al; bus.hs = 2'b00; bus.ls = 2'b11; cyc();
    bus.ah_in = ah; bus.hs = 2'b00; bus.ls = 2'b00; cyc();
    idle_in();
  endtask

  task automatic launch(input int unsigned sh, input bit d, input logic [1:0] fm);
    bus.start = 1; bus.shamt = SW'(sh); bus.dir = d; bus.fmode = fm; cyc();
    bus.start = 0;
  endtask

  task automatic busy_len(output int unsigned n);
    n = 0;
    while (bus.busy && n < 100) begin n++; cyc(); end
  endtask

  int unsigned n;

  initial begin
    clr_n = 0;
    bus.ah_reset = 0; bus.ah_inen = 0; bus.ah_in = '0; bus.aludata = '0;
    bus.carry_out = 0; bus.hs = 2'b11; bus.ls = 2'b11; bus.start = 0;
    bus.shamt = '0; bus.dir = 0; bus.fmode = 2'b00;
    repeat (3) cyc();
    chk("rst_ah", int'(bus.ah_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    clr_n = 1;
    cyc();

    // manual load then shl with carry
    bus.ah_inen = 1; bus.ah_in = 8'hA5; bus.hs = 2'b00; bus.ls = 2'b11; cyc();
    idle_in();
    chk("man_load_ah", int'(bus.ah_out), 'hA5);
    chk("man_load_al", int'(bus.al_out), 'h00);
    bus.hs = 2'b01; bus.ls = 2'b01; bus.carry_out = 1; cyc();
    idle_in(); bus.carry_out = 0;
    chk("man_shl_ah", int'(bus.ah_out), 'h4A);
    chk("man_shl_al", int'(bus.al_out), 'h01);

    // arithmetic right shift by 4
    set_pair(8'h80, 8'h00);
    launch(4, 1, 2'b01);
    busy_len(n);
    chk("arith_busy_len", n, 4);
    chk("arith_done", int'(bus.done), 1);
    chk("arith_ah", int'(bus.ah_out), 'hF8);
    chk("arith_al", int'(bus.al_out), 'h00);
    chk("arith_flag", int'(bus.sh_flag), 0);
    cyc();
    chk("arith_done_pulse", int'(bus.done), 0);

    // rotate fill by 1 to the right
    set_pair(8'h00, 8'h01);
    launch(1, 1, 2'b11);
    cyc();
`ifdef ROTATE_EN
    chk("rot_ah", int'(bus.ah_out), 'h80);
`else
    chk("rot_ah", int'(bus.ah_out), 'h00);
`endif
    chk("rot_al", int'(bus.al_out), 'h00);
    chk("rot_flag", int'(bus.sh_flag), 1);
    chk("rot_done", int'(bus.done), 1);

    // shamt 0: done only
    launch(0, 0, 2'b00);
    chk("sh0_busy", int'(bus.busy), 0);
    chk("sh0_done", int'(bus.done), 1);
    cyc();
    chk("sh0_done_low", int'(bus.done), 0);

    // saturating logical shift, start pulses during busy are ignored
    set_pair(8'hFF, 8'hFF);
    launch(31, 0, 2'b00);
    cyc(); cyc();
    bus.start = 1; bus.shamt = 5'd3; bus.hs = 2'b00; cyc();
    idle_in();
    busy_len(n);
    chk("sat_busy_len", n + 3, 16);
    chk("sat_ah", int'(bus.ah_out), 0);
    chk("sat_al", int'(bus.al_out), 0);

    // abort in the 2nd busy cycle
    set_pair(8'h12, 8'h34);
    launch(5, 0, 2'b00);
    cyc();
    bus.ah_reset = 1; cyc();
    bus.ah_reset = 0;
    chk("abort_ah", int'(bus.ah_out), 'h00);
    chk("abort_al", int'(bus.al_out), 'h68);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    cyc();
    chk("abort_no_done", int'(bus.done), 0);

    // async reset mid-sequence
    set_pair(8'h5A, 8'hC3);
    launch(10, 1, 2'b10);
    cyc();
    #2 clr_n = 0;
    #1;
    chk("arst_ah", int'(bus.ah_out), 0);
    chk("arst_al", int'(bus.al_out), 0);
    chk("arst_busy", int'(bus.busy), 0);
    cyc();
    #2 clr_n = 1;
    repeat (12) begin
      cyc();
      chk("arst_no_done", int'(bus.done), 0);
    end

    // random traffic checked cycle by cycle against the model
    repeat (3000) begin
      bus.ah_reset  = ($urandom_range(0, 19) == 0);
      bus.ah_inen   = 1'($urandom_range(0, 1));
      bus.ah_in     = 8'($urandom);
      bus.aludata   = 8'($urandom);
      bus.carry_out = 1'($urandom_range(0, 1));
      bus.hs        = 2'($urandom_range(0, 3));
      bus.ls        = 2'($urandom_range(0, 3));
      bus.start     = ($urandom_range(0, 5) == 0);
      bus.shamt     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 6));
      bus.dir       = 1'($urandom_range(0, 1));
      bus.fmode     = 2'($urandom_range(0, 3));
      cyc();
    end
    idle_in();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
